// File: rtl/lfsr_sequence_checker_if.sv
// Bundle of data-side and status-side signals of the LFSR sequence checker.
// The master side (source of received words) drives data and clear. The slave
// side (the checker) reports lock status, error pulses and the error count.
interface lfsr_sequence_checker_if #(
  parameter int ERR_W = 16
);
  logic [31:0]      data_i;
  logic             data_v;
  logic             clr_i;
  logic             locked_o;
  logic             err_o;
  logic             lost_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic             zero_o;

  modport master (
    output data_i, data_v, clr_i,
    input  locked_o, err_o, lost_o, err_cnt_o, zero_o
  );

  modport slave (
    input  data_i, data_v, clr_i,
    output locked_o, err_o, lost_o, err_cnt_o, zero_o
  );
endinterface

// File: rtl/lfsr_sequence_checker.sv
// LFSR sequence checker.
// Hunts for a nonzero seed word, then verifies that LOCK_COUNT consecutive
// words follow the generator step before declaring lock. While locked, the
// reference free-runs one step per valid word, so a single corrupted word is
// counted once and does not poison the following comparisons. LOSS_COUNT
// consecutive misses drop lock and return to hunting.
module lfsr_sequence_checker #(
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  lfsr_sequence_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Counters stop at the last value before the threshold, so 8 bits cover
  // the full 1..255 parameter range.
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]       LOSS_LAST = 8'(LOSS_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state;
  logic [31:0]      ref_word;
  logic [31:0]      expected;
  logic             match;
  logic             zero_word;
  logic [7:0]       match_cnt;
  logic [7:0]       miss_cnt;
  logic             locked;
  logic             err;
  logic             lost;
  logic             zero;
  logic [ERR_W-1:0] err_cnt;

  // One generator step: new MSB is the tap parity, the rest shifts right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {r[31] ^ r[30] ^ r[29] ^ r[27] ^ r[25] ^ r[0], r[31:1]};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  // Compare the incoming word against the next expected generator state.
  always_comb begin
    expected  = lfsr_step(ref_word);
    match     = (bus.data_i == expected);
    zero_word = (bus.data_i == 32'd0);
  end

  // Hunt/verify/lock state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      ref_word  <= 32'd0;
      match_cnt <= 8'd0;
      miss_cnt  <= 8'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      lost      <= 1'b0;
      zero      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err  <= 1'b0;
      lost <= 1'b0;
      zero <= 1'b0;
      if (bus.data_v) begin
        case (state)
          HUNT: begin
            if (zero_word) begin
              zero <= 1'b1;
            end else begin
              ref_word  <= bus.data_i;
              match_cnt <= 8'd0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              ref_word <= bus.data_i;
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= 8'd0;
                miss_cnt  <= 8'd0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else if (zero_word) begin
              state <= HUNT;
            end else begin
              // Treat the unexpected word as a fresh seed.
              ref_word  <= bus.data_i;
              match_cnt <= 8'd0;
            end
          end
          LOCKED: begin
            ref_word <= expected;
            if (match) begin
              miss_cnt <= 8'd0;
            end else begin
              err     <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
              if (miss_cnt == LOSS_LAST) begin
                state    <= HUNT;
                locked   <= 1'b0;
                lost     <= 1'b1;
                miss_cnt <= 8'd0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear overrides any increment made in the same cycle.
      if (bus.clr_i) begin
        err_cnt <= '0;
      end
    end
  end

  assign bus.locked_o  = locked;
  assign bus.err_o     = err;
  assign bus.lost_o    = lost;
  assign bus.zero_o    = zero;
  assign bus.err_cnt_o = err_cnt;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Bench for the LFSR sequence checker: directed vector table on a
// LOCK_COUNT=3 / LOSS_COUNT=4 instance, hand sequences for LOCK_COUNT=1 and
// counter saturation on a narrow-counter instance, then random traffic on both
// instances compared against a word-level reference model.
module tb_lfsr_sequence_checker;

  logic clk;
  logic rst;

  lfsr_sequence_checker_if #(.ERR_W(16)) if_a ();
  lfsr_sequence_checker_if #(.ERR_W(3))  if_b ();

  lfsr_sequence_checker #(.LOCK_COUNT(3), .LOSS_COUNT(4), .ERR_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  lfsr_sequence_checker #(.LOCK_COUNT(1), .LOSS_COUNT(2), .ERR_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          r;
    bit          v;
    bit          c;
    logic [31:0] d;
    bit          l;
    bit          e;
    bit          lo;
    bit          z;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  // Generator step computed as parity-of-taps and a plain right shift.
  function automatic logic [31:0] s_next(input logic [31:0] r);
    logic fb;
    fb = ^(r & 32'hEA00_0001);
    return (r >> 1) | ({31'd0, fb} << 31);
  endfunction

  function automatic logic [63:0] packv(input bit l, input bit e, input bit lo,
                                        input bit z, input int cnt);
    return {28'd0, l, e, lo, z, cnt[31:0]};
  endfunction

  function automatic logic [63:0] act_a();
    return packv(if_a.locked_o, if_a.err_o, if_a.lost_o, if_a.zero_o,
                 int'(if_a.err_cnt_o));
  endfunction

  function automatic logic [63:0] act_b();
    return packv(if_b.locked_o, if_b.err_o, if_b.lost_o, if_b.zero_o,
                 int'(if_b.err_cnt_o));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {lk,err,lost,zero,cnt}=%h, required %h", name, act, exp);
    end
  endtask

  // Drive both instances with the same inputs and step one clock.
  task automatic apply(input bit r, input bit v, input logic [31:0] d, input bit c);
    rst         = r;
    if_a.data_v = v;
    if_a.data_i = d;
    if_a.clr_i  = c;
    if_b.data_v = v;
    if_b.data_i = d;
    if_b.clr_i  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, input bit v, input logic [31:0] d, input bit c,
                     input bit l, input bit e, input bit lo, input bit z, input int cnt);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.c = c;
    t.l = l; t.e = e; t.lo = lo; t.z = z; t.cnt = cnt;
    tbl.push_back(t);
  endtask

  // ---------------- reference model (two instances) ----------------
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
  int          lockc[2] = '{3, 1};
  int          lossc[2] = '{4, 2};
  int          maxc[2]  = '{65535, 7};
  int          m_mode[2];
  logic [31:0] m_ref[2];
  int          m_run[2];
  int          m_miss[2];
  int          m_cnt[2];
  bit          m_err[2];
  bit          m_lost[2];
  bit          m_zero[2];

  task automatic model(input int k, input bit r, input bit v, input logic [31:0] d,
                       input bit c);
    logic [31:0] want;
    m_err[k]  = 0;
    m_lost[k] = 0;
    m_zero[k] = 0;
    if (!r) begin
      m_mode[k] = M_HUNT;
      m_ref[k]  = 32'd0;
      m_run[k]  = 0;
      m_miss[k] = 0;
      m_cnt[k]  = 0;
      return;
    end
    if (v) begin
      want = s_next(m_ref[k]);
      if (m_mode[k] == M_HUNT) begin
        if (d == 32'd0) m_zero[k] = 1;
        else begin
          m_ref[k]  = d;
          m_run[k]  = 0;
          m_mode[k] = M_VERIFY;
        end
      end else if (m_mode[k] == M_VERIFY) begin
        if (d == want) begin
          m_ref[k] = d;
          m_run[k] = m_run[k] + 1;
          if (m_run[k] >= lockc[k]) begin
            m_mode[k] = M_LOCKED;
            m_miss[k] = 0;
          end
        end else if (d == 32'd0) begin
          m_mode[k] = M_HUNT;
        end else begin
          m_ref[k] = d;
          m_run[k] = 0;
        end
      end else begin
        m_ref[k] = want;
        if (d == want) m_miss[k] = 0;
        else begin
          m_err[k]  = 1;
          m_cnt[k]  = (m_cnt[k] < maxc[k]) ? m_cnt[k] + 1 : m_cnt[k];
          m_miss[k] = m_miss[k] + 1;
          if (m_miss[k] >= lossc[k]) begin
            m_mode[k] = M_HUNT;
            m_lost[k] = 1;
          end
        end
      end
    end
    if (c) m_cnt[k] = 0;
  endtask

  function automatic logic [63:0] exp_model(input int k);
    return packv(m_mode[k] == M_LOCKED, m_err[k], m_lost[k], m_zero[k], m_cnt[k]);
  endfunction

  task automatic rand_cycle(input int i, input bit r, input bit v, input logic [31:0] d,
                            input bit c);
    apply(r, v, d, c);
    model(0, r, v, d, c);
    model(1, r, v, d, c);
    check($sformatf("rand_a[%0d]", i), act_a(), exp_model(0));
    check($sformatf("rand_b[%0d]", i), act_b(), exp_model(1));
  endtask

  // Bound on total run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] g;
    rst = 1'b0;
    if_a.data_v = 1'b0; if_a.data_i = 32'd0; if_a.clr_i = 1'b0;
    if_b.data_v = 1'b0; if_b.data_i = 32'd0; if_b.clr_i = 1'b0;

    // ---------------- directed table for instance A ----------------
    add(0, 1, 32'h0000_0001, 0, 0, 0, 0, 0, 0);      // reset, data_v ignored
    add(1, 1, 32'h0000_0000, 0, 0, 0, 0, 1, 0);      // zero word in HUNT
    g = 32'h0000_0001;
    add(1, 1, g, 0, 0, 0, 0, 0, 0);                  // seed -> VERIFY
    add(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);      // idle holds
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);   // 0x80000000
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);   // 0xC0000000
    g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, 0);   // 0x60000000 -> locked
    add(1, 0, 32'h0, 0, 1, 0, 0, 0, 0);              // idle while locked
    g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g ^ 32'h0000_0100, 0, 1, 1, 0, 0, 1);  // one bit flip
    g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, 1);   // recovers, no error
    for (int i = 1; i <= 4; i++) begin
      g = s_next(g);
      add(1, 1, ~g, 0, (i < 4), 1, (i == 4), 0, 1 + i);
    end
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0);              // clear while idle
    g = 32'h0000_ACE1; add(1, 1, g, 0, 0, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);   // two matches
    g = 32'h1234_5678; add(1, 1, g, 0, 0, 0, 0, 0, 0);  // reseed
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, 0);   // relock
    for (int i = 1; i <= 5; i++) begin
      g = s_next(g); add(1, 1, ~g, 0, 1, 1, 0, 0, i);
      g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, i);
    end
    g = s_next(g); add(1, 1, ~g, 1, 1, 1, 0, 0, 0);  // clear beats increment
    g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      g = s_next(g);
      add(1, 1, ~g, 0, (i < 4), 1, (i == 4), 0, i);
    end
    add(1, 1, 32'h5A5A_0001, 0, 0, 0, 0, 0, 4);      // HUNT -> VERIFY
    add(1, 1, 32'h0, 0, 0, 0, 0, 0, 4);              // zero in VERIFY -> HUNT
    add(1, 1, 32'h0, 0, 0, 0, 0, 1, 4);              // zero pulses in HUNT
    g = 32'h0BAD_F00D; add(1, 1, g, 0, 0, 0, 0, 0, 4);
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 4);
    g = s_next(g); add(0, 1, g, 0, 0, 0, 0, 0, 0);   // reset mid-VERIFY
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);   // treated as seed
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g, 0, 0, 0, 0, 0, 0);
    g = s_next(g); add(1, 1, g, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("vec_a[%0d]", i), act_a(),
            packv(tbl[i].l, tbl[i].e, tbl[i].lo, tbl[i].z, tbl[i].cnt));
    end

    // ------- instance B: single-match lock, saturation at 7, loss at 2 -------
    apply(0, 0, 32'h0, 0);
    check("b_reset", act_b(), packv(0, 0, 0, 0, 0));
    g = 32'h0000_0001;
    apply(1, 1, g, 0);
    check("b_seed", act_b(), packv(0, 0, 0, 0, 0));
    g = s_next(g); apply(1, 1, g, 0);
    check("b_lock1", act_b(), packv(1, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      g = s_next(g); apply(1, 1, ~g, 0);
      check($sformatf("b_sat_miss[%0d]", i), act_b(), packv(1, 1, 0, 0, (i < 7) ? i : 7));
      g = s_next(g); apply(1, 1, g, 0);
      check($sformatf("b_sat_hit[%0d]", i), act_b(), packv(1, 0, 0, 0, (i < 7) ? i : 7));
    end
    g = s_next(g); apply(1, 1, ~g, 0);
    check("b_miss1", act_b(), packv(1, 1, 0, 0, 7));
    g = s_next(g); apply(1, 1, ~g, 0);
    check("b_lost", act_b(), packv(0, 1, 1, 0, 7));

    // ---------------- random traffic against the model ----------------
    rand_cycle(0, 0, 0, 32'h0, 0);
    g = $urandom() | 32'h1;
    for (int i = 1; i <= 1500; i++) begin
      int          sel;
      bit          r, v, c;
      logic [31:0] d;
      r   = ($urandom_range(0, 299) != 0);
      c   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 75) begin
        g = s_next(g); d = g;
      end else if (sel < 85) begin
        g = s_next(g); d = g ^ (32'h1 << $urandom_range(0, 31));
      end else if (sel < 90) begin
        d = 32'h0;
      end else begin
        g = $urandom(); d = g;
      end
      rand_cycle(i, r, v, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
